// File: rtl/hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_ctrl_if
// Description : Control, operand and result signals between the main control
//               unit, the multiply/divide units and the HI/LO sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_ctrl_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_b;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wr_data;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        unit_reset;
    logic        mult_control;
    logic        div_control;
    logic        busy;
    logic        done;
    logic        div0_exc;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    // Control unit and arithmetic units side
    modport master (
        output start_mult, start_div, op_b, mthi_we, mtlo_we, wr_data,
        output mult_hi, mult_lo, div_hi, div_lo,
        input  unit_reset, mult_control, div_control, busy, done, div0_exc,
        input  hi_out, lo_out
    );

    // Sequencer side
    modport slave (
        input  start_mult, start_div, op_b, mthi_we, mtlo_we, wr_data,
        input  mult_hi, mult_lo, div_hi, div_lo,
        output unit_reset, mult_control, div_control, busy, done, div0_exc,
        output hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_ctrl
// Description : Sequences the multi-cycle multiplier/divider and holds the
//               architectural HI/LO register pair.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_ctrl #(
    parameter int CYCLES = 32,
    parameter int CNT_W  = 6
) (
    input  wire logic  clk,
    input  wire logic  reset,
    hilo_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic             SEL_MULT = 1'b0;
    localparam logic             SEL_DIV  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               sel_q,    sel_d;
    logic [31:0]        hi_q,     hi_d;
    logic [31:0]        lo_q,     lo_d;
    logic               done_q,   done_d;
    logic               div0_q,   div0_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Register writes land even when a start is accepted this cycle;
                // the capture overwrites them later.
                if (bus.mthi_we) begin
                    hi_d = bus.wr_data;
                end
                if (bus.mtlo_we) begin
                    lo_d = bus.wr_data;
                end
                if (bus.start_mult) begin
                    sel_d   = SEL_MULT;
                    state_d = ST_CLEAR;
                end else if (bus.start_div) begin
                    if (bus.op_b != 32'd0) begin
                        sel_d   = SEL_DIV;
                        state_d = ST_CLEAR;
                    end else begin
                        div0_d  = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (sel_q == SEL_DIV) begin
                    hi_d = bus.div_hi;
                    lo_d = bus.div_lo;
                end else begin
                    hi_d = bus.mult_hi;
                    lo_d = bus.mult_lo;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_MULT;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // The units must be held clear for as long as reset is asserted, so reset
    // is ORed in directly rather than waiting for the state register.
    assign bus.unit_reset   = reset | (state_q == ST_CLEAR);
    assign bus.mult_control = (state_q == ST_RUN) && (sel_q == SEL_MULT);
    assign bus.div_control  = (state_q == ST_RUN) && (sel_q == SEL_DIV);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.div0_exc     = div0_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;

endmodule
`default_nettype wire
